// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with OVERSAMPLE-x mid-bit sampling and a one-byte holding register.
// Define UART_RX_MAJORITY_EN to take each sample as a 2-of-3 vote over the last three baud ticks.
module uart_rx #(
  parameter int OVERSAMPLE = 8,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic                 rx_serial,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);
  // state | meaning
  // IDLE  | line high, waiting for it to go low
  // START | qualifying the start bit at its midpoint
  // DATA  | sampling DATA_BITS data bits, LSB first
  // STOP  | sampling the stop bit and updating the holding register

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_nxt;

  logic                 sync_1, line;
  logic                 sample;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 mid_tick, end_tick;
  logic                 bit_take, stop_take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b1;
      line   <= 1'b1;
    end else begin
      sync_1 <= rx_serial;
      line   <= sync_1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist <= 2'b11;
    else if (baud_tick) hist <= {hist[0], line};
  end

  assign sample = (line & hist[0]) | (line & hist[1]) | (hist[0] & hist[1]);
`else
  assign sample = line;
`endif

  assign mid_tick = baud_tick && (cnt == CNT_HALF);
  assign end_tick = baud_tick && (cnt == CNT_FULL);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bit_take  = 1'b0;
    stop_take = 1'b0;
    case (state)
      IDLE:  if (!line) state_nxt = START;
      START: if (mid_tick) state_nxt = sample ? IDLE : DATA;
      DATA: begin
        if (end_tick) begin
          bit_take = 1'b1;
          if (bit_idx == IDX_LAST) state_nxt = STOP;
        end
      end
      STOP: begin
        if (end_tick) begin
          stop_take = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counter restarts on every state change so each state times from its own entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (state_nxt != state) cnt <= '0;
    else if (baud_tick)          cnt <= (cnt == CNT_FULL) ? '0 : cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx   <= '0;
      shift_reg <= '0;
    end else if (state == START && state_nxt == DATA) begin
      bit_idx <= '0;
    end else if (bit_take) begin
      bit_idx   <= bit_idx + 1'b1;
      shift_reg <= {sample, shift_reg[DATA_BITS-1:1]};
    end
  end

  // A simultaneous consume frees the holding register for the byte finishing this clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_take && !sample;
      overrun   <= stop_take && sample && rx_valid && !rx_ready;
      if (stop_take && sample && (!rx_valid || rx_ready)) begin
        rx_data  <= shift_reg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
